sha_mem_responder: RTL

SHA_MEM_RESPONDER -- requirements
Module: sha_mem_responder

---
 rtl/sha_pkg.sv | 17 +
 rtl/sha_result_capture.sv | 86 ++++++++
 rtl/sha_mem_responder.sv | 77 +++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA memory responder and its result capture.
`default_nettype none

package sha_pkg;

   localparam int HASH_WORDS = 8;
   localparam int WORD_W     = 32;

   typedef enum logic [1:0] {
      CAP_IDLE = 2'd0,
      CAP_FILL = 2'd1,
      CAP_DONE = 2'd2
   } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/sha_result_capture.sv
// Snoops core writes into the 8-word hash result window and presents the
// assembled 256-bit result with a one-cycle valid pulse.
`default_nettype none

module sha_result_capture
   import sha_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         wr_en,
   input  logic [15:0]                  addr,
   input  logic [WORD_W-1:0]            wdata,
   input  logic [15:0]                  out_base,
   output logic                         hash_valid,
   output logic [HASH_WORDS*WORD_W-1:0] hash_out,
   output logic [7:0]                   hash_count
);

   cap_state_t  state, state_nx;
   logic [7:0]  mask, mask_nx;
   logic [16:0] offset;
   logic        win_hit;
   logic [2:0]  win_idx;
   logic [7:0]  win_bit;

   // Unsigned 17-bit difference keeps the window from wrapping past 16'hFFFF.
   assign offset  = {1'b0, addr} - {1'b0, out_base};
   assign win_hit = wr_en && (addr >= out_base) && (offset < 17'd8);
   assign win_idx = offset[2:0];
   assign win_bit = 8'b1 << win_idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CAP_IDLE;
         mask  <= 8'h00;
      end else begin
         state <= state_nx;
         mask  <= mask_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      mask_nx    = mask;
      hash_valid = 1'b0;
      unique case (state)
         CAP_IDLE: begin
            mask_nx  = win_hit ? win_bit : 8'h00;
            state_nx = win_hit ? CAP_FILL : CAP_IDLE;
         end
         CAP_FILL: begin
            if (win_hit) begin
               mask_nx = mask | win_bit;
               if ((mask | win_bit) == 8'hFF) state_nx = CAP_DONE;
            end
         end
         CAP_DONE: begin
            hash_valid = 1'b1;
            mask_nx    = win_hit ? win_bit : 8'h00;
            state_nx   = win_hit ? CAP_FILL : CAP_IDLE;
         end
         default: begin
            mask_nx  = 8'h00;
            state_nx = CAP_IDLE;
         end
      endcase
   end

   // Count on entry to CAP_DONE so the new count is visible alongside hash_valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hash_count <= 8'h00;
      else if (state == CAP_FILL && state_nx == CAP_DONE) hash_count <= hash_count + 8'd1;
   end

   for (genvar i = 0; i < HASH_WORDS; i++) begin : g_word
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            hash_out[(HASH_WORDS-1-i)*WORD_W +: WORD_W] <= '0;
         else if (win_hit && win_idx == 3'(i))
            hash_out[(HASH_WORDS-1-i)*WORD_W +: WORD_W] <= wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sha_mem_responder.sv
// Dual-access word memory for a SHA core: continuous core port, stalling host
// port, sticky out-of-range flag and hash result capture.
`default_nettype none

module sha_mem_responder
   import sha_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         mem_we,
   input  logic [15:0]                  mem_addr,
   input  logic [WORD_W-1:0]            mem_write_data,
   output logic [WORD_W-1:0]            mem_read_data,
   input  logic                         host_req,
   input  logic                         host_we,
   input  logic [15:0]                  host_addr,
   input  logic [WORD_W-1:0]            host_wdata,
   output logic                         host_ready,
   output logic                         host_rvalid,
   output logic [WORD_W-1:0]            host_rdata,
   input  logic [15:0]                  out_base,
   output logic                         hash_valid,
   output logic [HASH_WORDS*WORD_W-1:0] hash_out,
   output logic [7:0]                   hash_count,
   output logic                         err_oob
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_W-1:0] storage [DEPTH];
   logic              core_in, host_in, host_wr, host_rd;

   assign core_in    = ({1'b0, mem_addr}  < 17'(DEPTH));
   assign host_in    = ({1'b0, host_addr} < 17'(DEPTH));
   assign host_ready = host_req && !(host_we && mem_we);
   assign host_wr    = host_ready && host_we;
   assign host_rd    = host_req && !host_we;

   // Storage is deliberately not reset; host_ready guarantees a single writer.
   always_ff @(posedge clk) begin
      if (mem_we && core_in)
         storage[mem_addr[AW-1:0]] <= mem_write_data;
      else if (host_wr && host_in)
         storage[host_addr[AW-1:0]] <= host_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_read_data <= '0;
         host_rvalid   <= 1'b0;
         host_rdata    <= '0;
         err_oob       <= 1'b0;
      end else begin
         mem_read_data <= core_in ? storage[mem_addr[AW-1:0]] : '0;
         host_rvalid   <= host_rd;
         if (host_rd) host_rdata <= host_in ? storage[host_addr[AW-1:0]] : '0;
         if (!core_in || (host_ready && !host_in)) err_oob <= 1'b1;
      end
   end

   sha_result_capture u_capture (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (mem_we),
      .addr       (mem_addr),
      .wdata      (mem_write_data),
      .out_base   (out_base),
      .hash_valid (hash_valid),
      .hash_out   (hash_out),
      .hash_count (hash_count)
   );

endmodule

`default_nettype wire
